// File: rtl/seq_magnitude_comparator.sv
// rtl/seq_magnitude_comparator.sv - multi-cycle MSB-first digit-serial magnitude comparator
// Optional two's-complement ordering via COMPARATOR_SIGNED_EN.
module seq_magnitude_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
`ifdef COMPARATOR_SIGNED_EN
  input  logic             signed_mode,
`endif
  output logic             busy,
  output logic             done,
  output logic             g,
  output logic             l,
  output logic             eq
);

  localparam int NSTEP = WIDTH / DIGIT;
  localparam int IDX_W = (NSTEP > 1) ? $clog2(NSTEP) : 1;
  localparam logic [IDX_W-1:0] IDX_TOP  = IDX_W'(NSTEP - 1);
  localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

  typedef enum logic {S_IDLE, S_RUN} state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] a_r, b_r;
  logic [IDX_W-1:0] idx;
  logic [DIGIT-1:0] a_dig, b_dig, flip;
  logic             accept, dec_gt, dec_lt, dec_eq, decided;

`ifdef COMPARATOR_SIGNED_EN
  logic signed_r;

  // Inverting the sign bit of both top digits maps two's-complement order onto unsigned order.
  assign flip = (signed_r && (idx == IDX_TOP)) ? MSB_MASK : '0;

  always_ff @(posedge clk) begin
    if (accept) signed_r <= signed_mode;
  end
`else
  assign flip = '0;
`endif

  assign busy    = (state == S_RUN);
  assign decided = dec_gt | dec_lt | dec_eq;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    dec_gt    = 1'b0;
    dec_lt    = 1'b0;
    dec_eq    = 1'b0;
    a_dig     = a_r[idx*DIGIT +: DIGIT] ^ flip;
    b_dig     = b_r[idx*DIGIT +: DIGIT] ^ flip;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (a_dig > b_dig) begin
          dec_gt    = 1'b1;
          state_nxt = S_IDLE;
        end else if (a_dig < b_dig) begin
          dec_lt    = 1'b1;
          state_nxt = S_IDLE;
        end else if (idx == '0) begin
          dec_eq    = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= S_IDLE;
      done  <= 1'b0;
      g     <= 1'b0;
      l     <= 1'b0;
      eq    <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= decided;
      if (accept) begin
        g  <= 1'b0;
        l  <= 1'b0;
        eq <= 1'b0;
      end
      if (dec_gt) g  <= 1'b1;
      if (dec_lt) l  <= 1'b1;
      if (dec_eq) eq <= 1'b1;
    end
  end

  // Operand and digit-index registers need no reset: they are always reloaded before use.
  always_ff @(posedge clk) begin
    if (accept) begin
      a_r <= a;
      b_r <= b;
      idx <= IDX_TOP;
    end else if (busy && !decided) begin
      idx <= idx - 1'b1;
    end
  end

endmodule

// File: tb/tb_seq_magnitude_comparator.sv
// tb/tb_seq_magnitude_comparator.sv - directed table-driven bench for seq_magnitude_comparator
module tb_seq_magnitude_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [15:0] a, b;
  logic        sm;
  logic        busy, done, g, l, eq;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  seq_magnitude_comparator #(.WIDTH(16), .DIGIT(2)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .a           (a),
    .b           (b),
`ifdef COMPARATOR_SIGNED_EN
    .signed_mode (sm),
`endif
    .busy        (busy),
    .done        (done),
    .g           (g),
    .l           (l),
    .eq          (eq)
  );

  typedef struct {
    string       name;
    logic [15:0] va;
    logic [15:0] vb;
    logic        vs;
    logic        eg;
    logic        el;
    logic        ee;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drives one compare; returns latency in cycles from the accepting edge (-1 on timeout)
  // and whether busy stayed high on every cycle before done.
  task automatic run_cmp(input logic [15:0] va, input logic [15:0] vb, input logic vs,
                         output int lat, output logic busy_ok);
    a = va; b = vb; sm = vs; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    busy_ok = busy;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
      if (!busy) busy_ok = 1'b0;
    end
  endtask

  initial begin
    int   lat;
    logic bok;
    int   seen;

    vecs.push_back('{"msb_gt",    16'h8000, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{"equal",     16'h1234, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 8});
    vecs.push_back('{"lsb_lt",    16'h0001, 16'h0002, 1'b0, 1'b0, 1'b1, 1'b0, 8});
    vecs.push_back('{"all_gt",    16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{"zero_eq",   16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1, 8});
    vecs.push_back('{"mid_lt",    16'h1234, 16'h1334, 1'b0, 1'b0, 1'b1, 1'b0, 4});
    vecs.push_back('{"mid_gt",    16'h00C0, 16'h0080, 1'b0, 1'b1, 1'b0, 1'b0, 5});
    vecs.push_back('{"msb_lt",    16'h4000, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1});
`ifdef COMPARATOR_SIGNED_EN
    vecs.push_back('{"s_neg_lt",  16'h8000, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0, 1});
    vecs.push_back('{"u_neg_gt",  16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 1'b0, 1});
    vecs.push_back('{"s_m1_gt",   16'hFFFF, 16'hFFFE, 1'b1, 1'b1, 1'b0, 1'b0, 8});
    vecs.push_back('{"s_max_gt",  16'h7FFF, 16'h8000, 1'b1, 1'b1, 1'b0, 1'b0, 1});
`endif

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; sm = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_glq", {g, l, eq}, 3'b000);
    rst_n = 1'b1;

    seen = 0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      if (busy || done) seen++;
    end
    check("idle_quiet", seen, 0);

    foreach (vecs[i]) begin
      run_cmp(vecs[i].va, vecs[i].vb, vecs[i].vs, lat, bok);
      check({vecs[i].name, "_lat"}, lat, vecs[i].lat);
      check({vecs[i].name, "_busy_run"}, bok, 1);
      check({vecs[i].name, "_busy_done"}, busy, 0);
      check({vecs[i].name, "_glq"}, {g, l, eq}, {vecs[i].eg, vecs[i].el, vecs[i].ee});
      @(posedge clk); #1;
      check({vecs[i].name, "_done_pulse"}, done, 0);
    end

    // Results hold while idle
    run_cmp(16'h1234, 16'h1234, 1'b0, lat, bok);
    repeat (3) @(posedge clk);
    #1;
    check("hold_glq", {g, l, eq}, 3'b001);
    check("hold_done", done, 0);

    // Back-to-back: start held in the done cycle is accepted
    run_cmp(16'h0001, 16'h0002, 1'b0, lat, bok);
    check("b2b_first_lat", lat, 8);
    check("b2b_first_l", {g, l, eq}, 3'b010);
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("b2b_accept_busy", busy, 1);
    check("b2b_cleared", {g, l, eq}, 3'b000);
    @(posedge clk); #1;
    check("b2b_second_done", done, 1);
    check("b2b_second_g", {g, l, eq}, 3'b100);

    // Start while busy is ignored
    a = 16'h0003; b = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    a = 16'hFFFF; b = 16'h0000; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int c = 4; c <= 20; c++) begin
      @(posedge clk); #1;
      if (done) begin
        lat = c;
        break;
      end
    end
    check("ignore_lat", lat, 8);
    check("ignore_glq", {g, l, eq}, 3'b001);

    // Reset mid-compare aborts without done
    a = 16'h0003; b = 16'h0003; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_busy_e4", busy, 0);
    check("abort_out_e4", {done, g, l, eq}, 4'b0000);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("abort_busy_e5", busy, 0);
    check("abort_out_e5", {done, g, l, eq}, 4'b0000);
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("abort_no_done", seen, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
